// File: rtl/rx_substate_checker_pkg.sv
// Shared definitions for the receive substate checker: substate codes, FSM states,
// and the per-substate required-OS-count / timeout-limit table.
package rx_substate_checker_pkg;

  localparam int DEF_MAX_LANES = 16;
  localparam int DEF_TMR_W     = 6;
  localparam int DEF_CNT_W     = 5;

  typedef enum logic [3:0] {
    SS_DETECT_QUIET   = 4'd0,
    SS_DETECT_ACTIVE  = 4'd1,
    SS_POLLING_ACTIVE = 4'd2,
    SS_POLLING_CONFIG = 4'd3,
    SS_CFG_LW_START   = 4'd4,
    SS_CFG_LW_ACCEPT  = 4'd5,
    SS_CFG_LN_WAIT    = 4'd6,
    SS_CFG_LN_ACCEPT  = 4'd7,
    SS_CFG_COMPLETE   = 4'd8,
    SS_CFG_IDLE       = 4'd9
  } substate_e;

  localparam logic [3:0] SS_FIRST_INVALID = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_COUNT  = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] lim;
  } os_rule_t;

  // Unknown substates return (0,0); they never reach COUNT anyway.
  function automatic os_rule_t substate_rule(input logic [3:0] sub);
    os_rule_t r;
    r = '{cnt: 8'd0, lim: 8'd0};
    case (sub)
      4'd0:                r = '{cnt: 8'd0, lim: 8'd12};
      4'd1:                r = '{cnt: 8'd0, lim: 8'd0};
      4'd2:                r = '{cnt: 8'd8, lim: 8'd24};
      4'd3:                r = '{cnt: 8'd8, lim: 8'd48};
      4'd4, 4'd5, 4'd7:    r = '{cnt: 8'd2, lim: 8'd24};
      4'd6:                r = '{cnt: 8'd2, lim: 8'd2};
      4'd8:                r = '{cnt: 8'd8, lim: 8'd24};
      4'd9:                r = '{cnt: 8'd8, lim: 8'd2};
      default:             r = '{cnt: 8'd0, lim: 8'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ltssm_tick_timer.sv
// Saturating tick counter with synchronous clear and a timeout compare against a limit.
module ltssm_tick_timer #(
  parameter int TMR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             tick,
  input  logic [TMR_W-1:0] limit,
  output logic             timeout
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (count >= limit);

endmodule

// File: rtl/rx_substate_checker.sv
// Checks that all snapshotted lanes reach the required ordered-set count for one
// LTSSM substate before a tick-based timeout, and reports pass/next-substate.
module rx_substate_checker
  import rx_substate_checker_pkg::*;
#(
  parameter int MAX_LANES = DEF_MAX_LANES,
  parameter int TMR_W     = DEF_TMR_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [3:0]           req_substate,
  output logic                 req_ready,
  input  logic [MAX_LANES-1:0] lane_mask,
  input  logic [MAX_LANES-1:0] lane_match,
  input  logic                 rx_elec_idle,
  input  logic                 force_detect,
  input  logic                 tick,
  output logic [MAX_LANES-1:0] os_chk_en,
  output logic [CNT_W-1:0]     os_req_cnt,
  output logic                 done,
  output logic                 pass,
  output logic [3:0]           exit_substate
);

  state_e               state, state_nxt;
  logic [3:0]           sub_q;
  logic [MAX_LANES-1:0] mask_q;
  logic [TMR_W-1:0]     lim_q;
  logic                 timeout;
  logic                 match;
  logic                 res_pass;
  os_rule_t             rule;

  assign rule = substate_rule(req_substate);

  ltssm_tick_timer #(.TMR_W(TMR_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == S_ARM),
    .enable  (state == S_COUNT),
    .tick    (tick),
    .limit   (lim_q),
    .timeout (timeout)
  );

  // An empty mask can never satisfy a nonzero count.
  assign match = (os_req_cnt == '0) ||
                 ((mask_q != '0) && ((lane_match & mask_q) == mask_q));

  always_comb begin
    state_nxt = state;
    res_pass  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (force_detect || (sub_q >= SS_FIRST_INVALID)) state_nxt = S_RESULT;
        else                                              state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (force_detect) begin
          state_nxt = S_RESULT;
        end else if (sub_q == SS_DETECT_QUIET) begin
          if (rx_elec_idle || timeout) begin
            state_nxt = S_RESULT;
            res_pass  = 1'b1;
          end
        end else if (os_req_cnt == '0) begin
          // Zero required count is satisfied immediately, even with a zero limit.
          state_nxt = S_RESULT;
          res_pass  = 1'b1;
        end else if (timeout) begin
          state_nxt = S_RESULT;
        end else if (match) begin
          state_nxt = S_RESULT;
          res_pass  = 1'b1;
        end
      end
      S_RESULT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      os_chk_en     <= '0;
      os_req_cnt    <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      exit_substate <= 4'd0;
      sub_q         <= 4'd0;
      mask_q        <= '0;
      lim_q         <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == S_IDLE);
      os_chk_en <= (state_nxt == S_COUNT) ? mask_q : '0;
      done      <= (state_nxt == S_RESULT);
      if (state_nxt == S_RESULT) begin
        pass          <= res_pass;
        exit_substate <= res_pass ? (sub_q + 4'd1) : 4'd0;
      end
      if ((state == S_IDLE) && req_valid) begin
        sub_q      <= req_substate;
        mask_q     <= lane_mask;
        os_req_cnt <= CNT_W'(rule.cnt);
        lim_q      <= TMR_W'(rule.lim);
      end
    end
  end

endmodule

// File: tb/tb_rx_substate_checker.sv
// Bench for rx_substate_checker: directed scenarios plus randomized requests
// checked against a transaction-level outcome model.
module tb_rx_substate_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_substate;
  logic        req_ready;
  logic [15:0] lane_mask;
  logic [15:0] lane_match;
  logic        rx_elec_idle;
  logic        force_detect;
  logic        tick;
  logic [15:0] os_chk_en;
  logic [4:0]  os_req_cnt;
  logic        done;
  logic        pass;
  logic [3:0]  exit_substate;

  int checks = 0;
  int errors = 0;

  rx_substate_checker dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_substate  (req_substate),
    .req_ready     (req_ready),
    .lane_mask     (lane_mask),
    .lane_match    (lane_match),
    .rx_elec_idle  (rx_elec_idle),
    .force_detect  (force_detect),
    .tick          (tick),
    .os_chk_en     (os_chk_en),
    .os_req_cnt    (os_req_cnt),
    .done          (done),
    .pass          (pass),
    .exit_substate (exit_substate)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Required count and tick limit for each substate.
  function automatic void rule_of(input logic [3:0] sub, output int cnt, output int lim);
    case (sub)
      0: begin cnt = 0; lim = 12; end
      1: begin cnt = 0; lim = 0;  end
      2: begin cnt = 8; lim = 24; end
      3: begin cnt = 8; lim = 48; end
      4, 5, 7: begin cnt = 2; lim = 24; end
      6: begin cnt = 2; lim = 2;  end
      8: begin cnt = 8; lim = 24; end
      9: begin cnt = 8; lim = 2;  end
      default: begin cnt = 0; lim = 0; end
    endcase
  endfunction

  // Outcome model: which COUNT cycle ends the check (-1 = straight from ARM) and the verdict.
  function automatic void predict(input logic [3:0] sub, input logic [15:0] mask, input logic [15:0] lm,
                                  input int m, input int per, input int e, input int f, input bit arm_force,
                                  output int c_done, output bit p, output logic [3:0] x);
    int cnt, lim, ticks;
    bit to, hit;
    rule_of(sub, cnt, lim);
    c_done = -1; p = 0; x = 4'd0;
    if (arm_force || sub >= 10) return;
    ticks = 0;
    for (int c = 0; c < 400; c++) begin
      to  = (ticks >= lim);
      hit = (mask != 0) && (c >= m) && ((lm & mask) == mask);
      c_done = c;
      if (c == f) return;
      if (sub == 0) begin
        if ((e >= 0 && c >= e) || to) begin p = 1; x = sub + 4'd1; return; end
      end else if (cnt == 0) begin
        p = 1; x = sub + 4'd1; return;
      end else if (to) begin
        return;
      end else if (hit) begin
        p = 1; x = sub + 4'd1; return;
      end
      if ((c % per) == per - 1 && ticks < 63) ticks++;
    end
    c_done = 999;
  endfunction

  task automatic run_req(input logic [3:0] sub, input logic [15:0] mask, input logic [15:0] lm,
                         input int m, input int per, input int e, input int f,
                         input bit arm_force, input bit hold, input string tag);
    int exp_c, got, cnt, lim;
    bit exp_p;
    logic [3:0] exp_x;
    predict(sub, mask, lm, m, per, e, f, arm_force, exp_c, exp_p, exp_x);
    rule_of(sub, cnt, lim);
    @(negedge clk);
    check({tag, ".ready"}, req_ready, 1);
    req_valid = 1; req_substate = sub; lane_mask = mask;
    @(posedge clk); #1;
    req_valid = hold; req_substate = 4'($urandom); lane_mask = 16'($urandom);
    force_detect = arm_force;
    check({tag, ".arm_cnt"}, os_req_cnt, cnt);
    check({tag, ".arm_en"}, os_chk_en, 0);
    @(posedge clk); #1;
    force_detect = 0;
    if (exp_c < 0) begin
      got = -1;
      check({tag, ".done_arm"}, done, 1);
    end else begin
      check({tag, ".cnt_en"}, os_chk_en, mask);
      got = 999;
      for (int c = 0; c < 400; c++) begin
        tick = ((c % per) == per - 1);
        lane_match = (c >= m) ? lm : 16'h0;
        rx_elec_idle = (e >= 0 && c >= e);
        force_detect = (c == f);
        @(posedge clk); #1;
        if (done) begin got = c; break; end
      end
      check({tag, ".done_cycle"}, got, exp_c);
    end
    req_valid = 0; tick = 0; lane_match = 0; rx_elec_idle = 0; force_detect = 0;
    check({tag, ".pass"}, pass, exp_p);
    check({tag, ".exit"}, exit_substate, exp_x);
    check({tag, ".res_en"}, os_chk_en, 0);
    @(posedge clk); #1;
    check({tag, ".done_1cyc"}, done, 0);
    check({tag, ".ready_after"}, req_ready, 1);
  endtask

  initial begin
    logic [15:0] mk, lmv;
    reset = 1; req_valid = 0; req_substate = 0; lane_mask = 0; lane_match = 0;
    rx_elec_idle = 0; force_detect = 0; tick = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.en", os_chk_en, 0);
    check("rst.cnt", os_req_cnt, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.exit", exit_substate, 0);
    check("rst.ready", req_ready, 1);
    @(negedge clk); reset = 0;

    // force_detect while idle has no effect
    @(negedge clk); force_detect = 1;
    @(posedge clk); #1;
    check("idle_force.done", done, 0);
    check("idle_force.ready", req_ready, 1);
    force_detect = 0;

    run_req(4'd2, 16'h000F, 16'h000F, 10, 2, -1, -1, 0, 0, "sub2_pass");
    run_req(4'd6, 16'h00FF, 16'h007F, 0, 1, -1, -1, 0, 0, "sub6_fail");
    run_req(4'd0, 16'h0003, 16'h0000, 0, 3, 9, -1, 0, 0, "sub0_eidle");
    run_req(4'd0, 16'h0003, 16'h0000, 0, 1, -1, -1, 0, 0, "sub0_timeout");
    run_req(4'd3, 16'h00F0, 16'h0000, 0, 2, -1, 4, 0, 1, "sub3_force");
    run_req(4'd12, 16'h0001, 16'h0001, 0, 1, -1, -1, 0, 0, "sub12");
    run_req(4'd1, 16'h0000, 16'h0000, 0, 1, -1, -1, 0, 0, "sub1");
    run_req(4'd4, 16'h0000, 16'hFFFF, 0, 1, -1, -1, 0, 0, "mask0");
    run_req(4'd9, 16'h0001, 16'h0001, 2, 1, -1, -1, 0, 0, "tmo_eq_match");
    run_req(4'd9, 16'h0001, 16'h0001, 1, 1, -1, -1, 0, 0, "sub9_pass");
    run_req(4'd5, 16'h0101, 16'h0101, 3, 1, -1, -1, 1, 0, "arm_force");

    // Reset in the middle of a COUNT phase; previous exit must be held until then.
    run_req(4'd2, 16'h000F, 16'h000F, 3, 2, -1, -1, 0, 0, "pre_reset");
    @(negedge clk); req_valid = 1; req_substate = 4'd3; lane_mask = 16'h000F;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1;
    check("mid.en", os_chk_en, 16'h000F);
    check("mid.exit_held", exit_substate, 3);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    check("midrst.en", os_chk_en, 0);
    check("midrst.cnt", os_req_cnt, 0);
    check("midrst.done", done, 0);
    check("midrst.pass", pass, 0);
    check("midrst.exit", exit_substate, 0);
    @(negedge clk); reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("postrst.done", done, 0);
    end
    check("postrst.ready", req_ready, 1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] s;
      int m, per, e, f;
      s = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      mk = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      case ($urandom_range(0, 2))
        0: lmv = mk | 16'($urandom);
        1: lmv = mk & ~(16'h1 << $urandom_range(0, 15));
        default: lmv = 16'($urandom);
      endcase
      m   = $urandom_range(0, 30);
      per = $urandom_range(1, 4);
      e   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 40));
      f   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_req(s, mk, lmv, m, per, e, f, ($urandom_range(0, 15) == 0), 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
